// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: state encoding,
// operand width and the number of quotient-bit iterations.
package div_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
// Result is {remainder, quotient}, destined for HI/LO.
// Optional feature macro: DIV_SIGNED_EN -- when defined, signed_div_i selects
// signed division (magnitude conversion on capture, sign fix on completion);
// when undefined every division is unsigned and signed_div_i is ignored.
module div_unit #(
  parameter int DATA_W = div_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  import div_pkg::*;

  localparam int                CNT_W     = $clog2(DIV_ITER + 1);
  localparam logic [CNT_W-1:0]  ITER_LAST = CNT_W'(DIV_ITER);
  localparam int                WORK_W    = 2 * DATA_W + 1;

  div_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt;
  logic [WORK_W-1:0]        work;
  logic [DATA_W-1:0]        divisor;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W-1:0]        dividend_mag, divisor_mag;
  logic [DATA_W-1:0]        quot, rem;
  logic                     go;

  // Two's-complement negation used for magnitude conversion and sign fix.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign go   = start_i && !annul_i;
  assign diff = $signed({1'b0, work[2*DATA_W-1:DATA_W]}) - $signed({1'b0, divisor});

`ifdef DIV_SIGNED_EN
  logic neg_quot, neg_rem;

  assign dividend_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
  assign divisor_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;
  assign quot = neg_quot ? negate(work[DATA_W-1:0]) : work[DATA_W-1:0];
  assign rem  = neg_rem  ? negate(work[WORK_W-1:DATA_W+1]) : work[WORK_W-1:DATA_W+1];

  // Latch result signs when a request is accepted.
  always_ff @(posedge clk) begin
    if (state_q == FREE && go) begin
      neg_quot <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_rem  <= signed_div_i && opdata1_i[DATA_W-1];
    end
  end
`else
  logic unused_sign;

  assign unused_sign  = signed_div_i;
  assign dividend_mag = opdata1_i;
  assign divisor_mag  = opdata2_i;
  assign quot         = work[DATA_W-1:0];
  assign rem          = work[WORK_W-1:DATA_W+1];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (go) state_d = (opdata2_i == '0) ? BY_ZERO : ON;
      BY_ZERO: state_d = annul_i ? FREE : END;
      ON: begin
        if (annul_i)                state_d = FREE;
        else if (cnt == ITER_LAST)  state_d = END;
      end
      END:     if (!start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // Working register: operand capture, then one subtract-and-shift per clock.
  always_ff @(posedge clk) begin
    if (state_q == FREE && go) begin
      work    <= {{DATA_W{1'b0}}, dividend_mag, 1'b0};
      divisor <= divisor_mag;
    end else if (state_q == ON && cnt != ITER_LAST) begin
      if (diff[DATA_W]) work <= {work[WORK_W-2:0], 1'b0};
      else              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
    end
  end

  // Iteration counter and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state_q)
        FREE: begin
          cnt      <= '0;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
        BY_ZERO: begin
          ready_o  <= !annul_i;
          result_o <= '0;
        end
        ON: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt == ITER_LAST) begin
            ready_o  <= 1'b1;
            result_o <= {rem, quot};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (annul, reset mid-division, END hold) and randomized divisions
// checked against an arithmetic reference model.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp;
  int n_fail;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero;
  // divide by zero yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one division from a negedge, scramble operands after capture,
  // measure latency, hold start in END (with a stray annul), then release.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [63:0] res, output int lat);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    lat          = -1;
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    res = result_o;
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: ready never rose within 60 cycles", name);
    end
    for (int h = 0; h < 2; h++) begin
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_end_hold"}, {result_o[62:0], ready_o}, {res[62:0], 1'b1});
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_release"}, {ready_o, result_o[62:0]}, 64'd0);
  endtask

  vec_t        vecs[10];
  logic [63:0] res;
  int          lat;
  int          seen;

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;

    vecs[0] = '{"u_100_7",    32'd100,       32'd7,         1'b0, {32'd2, 32'd14}, 33};
    vecs[1] = '{"s_m7_2",     32'hFFFFFFF9,  32'd2,         1'b1,
                SIGNED_EN ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'd1, 32'h7FFFFFFC}, 33};
    vecs[2] = '{"s_7_m2",     32'd7,         32'hFFFFFFFE,  1'b1,
                SIGNED_EN ? {32'd1, 32'hFFFFFFFD} : {32'd7, 32'd0}, 33};
    vecs[3] = '{"s_ovf",      32'h80000000,  32'hFFFFFFFF,  1'b1,
                SIGNED_EN ? {32'd0, 32'h80000000} : {32'h80000000, 32'd0}, 33};
    vecs[4] = '{"u_max_1",    32'hFFFFFFFF,  32'd1,         1'b0, {32'd0, 32'hFFFFFFFF}, 33};
    vecs[5] = '{"div_zero",   32'd1234,      32'd0,         1'b0, 64'd0, 1};
    vecs[6] = '{"u_5_10",     32'd5,         32'd10,        1'b0, {32'd5, 32'd0}, 33};
    vecs[7] = '{"s_m100_m7",  32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1,
                SIGNED_EN ? {32'hFFFFFFFE, 32'd14} : {32'hFFFFFF9C, 32'd0}, 33};
    vecs[8] = '{"u_0_5",      32'd0,         32'd5,         1'b0, 64'd0, 33};
    vecs[9] = '{"s_zero",     32'hFFFFFFF9,  32'd0,         1'b1, 64'd0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Annul in ON: no result ever appears
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_on_ready", {63'd0, ready_o}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("annul_on_quiet", 64'(seen), 64'd0);
    run_div("after_annul", 32'hFFFFFFFF, 32'd1, 1'b0, res, lat);
    check("after_annul_result", res, {32'd0, 32'hFFFFFFFF});
    check("after_annul_latency", 64'(lat), 64'd33);

    // Annul in BY_ZERO
    opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_zero_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    check("annul_zero_quiet", {63'd0, ready_o}, 64'd0);

    // Request with annul high in FREE is ignored
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b1;
    repeat (5) @(negedge clk);
    check("annul_free_ready", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    run_div("after_free_annul", 32'd100, 32'd7, 1'b0, res, lat);
    check("after_free_annul_latency", 64'(lat), 64'd33);

    // Reset mid-division
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("rst_mid_quiet", 64'(seen), 64'd0);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        s;
      int          mode;
      a    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0, 1, 2: b = $urandom;
        3, 4:    b = 32'($urandom_range(1, 15));
        5:       b = 32'd0 - 32'($urandom_range(1, 15));
        6:       b = $urandom >> $urandom_range(0, 31);
        default: b = 32'd0;
      endcase
      if (b == 32'd0 && mode != 7) b = 32'd3;
      s = 1'($urandom_range(0, 1));
      run_div("rand", a, b, s, res, lat);
      check("rand_result", res, model(a, b, s));
      check("rand_latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider for the MIPS `DIV`/`DIVU` instructions. It sits in the execute stage, directly upstream of the HI/LO register pair. It accepts two operands and a signedness flag, and iterates one quotient bit per clock. It then presents a 64-bit result {remainder, quotient}, which the pipeline writes to HI and LO (HI = remainder, LO = quotient). The execute stage stalls the pipeline until `ready_o` rises.

## Interface
Parameters:
- `DATA_W`, 32: operand width; quotient and remainder are each `DATA_W` bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 selects signed `DIV`; 0 selects `DIVU`.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by the execute stage until it has consumed the result.
- `annul_i`  in  1  cancels an in-flight division (branch flush or exception).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; registered.
- `ready_o`  out  1  result valid; registered.

## Operation
- **States:** FREE, BY_ZERO, ON, END. Reset → FREE, `result_o` = 0, `ready_o` = 0, counter = 0.
- **FREE:**
  - If `start_i` is high and `annul_i` is low, capture the operands.
  - If `opdata2_i` == 0, go to BY_ZERO.
  - Otherwise go to ON with counter = 0.
  - If `start_i` is high and `annul_i` is also high, ignore the request and stay in FREE.
- **Signed capture:** a negative operand is converted to its two's-complement magnitude. The quotient sign (op1[31]^op2[31]) and the remainder sign (op1[31]) are latched.
- **ON:** working register is 65 bits, initialised to {32'b0, |dividend|, 1'b0}. Each edge performs one iteration:
  - Compute diff = work[63:32] − |divisor| as a 33-bit subtraction.
  - If diff is negative: work ← {work[63:0], 1'b0}.
  - Otherwise: work ← {diff[31:0], work[31:0], 1'b1}.
  - Increment the counter.
- **Completion:** when counter == 32, the quotient is work[31:0] and the remainder is work[64:33].
  - Apply the latched signs by negating each value when its sign flag is set.
  - Register `result_o`, set `ready_o` = 1, go to END.
- **BY_ZERO:** on the next edge go to END with `result_o` = 0 and `ready_o` = 1. The architecture leaves this result UNPREDICTABLE; the block fixes it at 0.
- **END:** hold `result_o` and `ready_o` while `start_i` stays high. When `start_i` goes low, the next edge returns to FREE with `result_o` = 0 and `ready_o` = 0.
- **annul_i:** in ON or BY_ZERO, the next edge forces FREE with `ready_o` = 0 and `result_o` = 0, and no result is produced. In END, `annul_i` is ignored.
- **Overflow:** −2^31 / −1 (signed) gives quotient 0x80000000, remainder 0. This is defined behaviour and raises no exception.
- **Operand stability:** operand changes after capture have no effect.

## Timing
- Let E0 be the edge that samples `start_i` in FREE.
  - Normal divide: iterations occur on E1..E32; E33 registers the result. `ready_o` is high from E33, giving a latency of 33 cycles.
  - Divide by zero: `ready_o` is high from E1.
- The earliest back-to-back issue is: `start_i` low for one cycle after `ready_o`, then high again.
- `rst` has priority over everything, including mid-division; the block returns to its reset values at that edge.

## Configuration
- **`DIV_SIGNED_EN` defined:** behaviour exactly as above.
- **`DIV_SIGNED_EN` undefined:** `signed_div_i` is ignored, every division is unsigned, and the sign-conversion and sign-fix logic is not compiled. `DIV` then returns the `DIVU` result.

## Structure
- **Package `div_pkg`:** state encoding (FREE = 2'b00, BY_ZERO = 2'b01, ON = 2'b10, END = 2'b11), `DATA_W`, and the iteration count constant `DIV_ITER` = 32.
- **Sub-modules:** none needed. The single iteration step is one inline subtract-and-shift; the FSM, counter and datapath live in one module.

## Test plan
- Unsigned: `opdata1_i` = 100, `opdata2_i` = 7, `signed_div_i` = 0 → at E33 `ready_o` = 1, `result_o` = {32'd2, 32'd14}.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also check 7 / −2 → quotient −3, remainder +1.
- Divide by zero: `opdata2_i` = 0 → `ready_o` = 1 at E1, `result_o` = 0. Then drop `start_i` → FREE, `ready_o` = 0 on the next edge.
- Annul mid-flight: assert `annul_i` at E10 → FREE at E11, `ready_o` never rises. A new start then completes correctly, e.g. 0xFFFFFFFF / 1 unsigned → {0, 0xFFFFFFFF}.
- Overflow and reset:
  - Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - Pulse `rst` at E20 of a division → outputs 0, state FREE at that edge.
- With `DIV_SIGNED_EN` undefined: −7 / 2 with `signed_div_i` = 1 → {32'd1, 32'h7FFFFFFC}.
